// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multicycle MIPS control FSM:
//               state codes, supported opcodes, ALUOp codes, datapath
//               mux select codes and the bundled control-strobe struct.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // FSM state encodings (4 bits, visible on state_o)
    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC_R = 4'd6;
    localparam logic [3:0] ST_RWB    = 4'd7;
    localparam logic [3:0] ST_EXEC_I = 4'd8;
    localparam logic [3:0] ST_IWB    = 4'd9;
    localparam logic [3:0] ST_BRANCH = 4'd10;
    localparam logic [3:0] ST_JAL    = 4'd11;
    localparam logic [3:0] ST_HALT   = 4'd15;

    // Supported opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // ALUOp codes consumed by the ALU-control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    // ALU operand-B select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Register-file write-data select
    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
    localparam logic [1:0] MEMTOREG_PC     = 2'b10;

    // All per-state control strobes, so the decoder can default them in one go
    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [1:0] alu_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // States that own the memory port and may stall on mem_ready
    function automatic logic is_mem_state(input logic [3:0] state);
        return (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mc_wait_timer
// Description : Memory-stall counter. Counts stalled cycles while inc is
//               high, clears on clr, and flags expired once MAX_WAIT stalled
//               cycles have been tolerated.
// Ports       : clk, rst (async, active-high)
//               clr     - clear the count (has priority over inc)
//               inc     - count one stalled cycle
//               expired - count has reached MAX_WAIT
// Revision    : 1.0 - initial release
// ============================================================================
module mc_wait_timer #(
    parameter int unsigned WAIT_W   = 8,
    parameter int unsigned MAX_WAIT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [WAIT_W-1:0] C_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_count;

    // Holds at the limit so the count can never wrap back below it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != C_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Moore FSM sequencing the shared multicycle MIPS datapath
//               (addu/subu, ori, lw, sw, beq, jal). Stalls on mem_ready,
//               halts with a sticky mem_err on a memory timeout.
// Ports       : clk, rst (async, active-high)
//               op        - IR[31:26], valid from DECODE onward
//               mem_ready - memory completes the current access
//               mem_req/MemRead/MemWrite/IorD     - memory port control
//               IRWrite/PCWrite/PCWriteCond/PCSource - IR and PC control
//               ALUSrcA/ALUSrcB/ExtOp/ALUOp        - ALU control
//               RegDst/MemtoReg/RegWrite           - register file control
//               instr_done/illegal_op - single-cycle status pulses
//               mem_err   - sticky memory timeout flag
//               state_o   - current state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_W   = 8,
    parameter int unsigned MAX_WAIT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [1:0] ALUOp,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state_o
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_mem_err;
    logic       w_mem_state;
    logic       w_expired;
    logic       w_timeout;
    logic       w_wait_clr;
    logic       w_wait_inc;
    ctrl_t      w_ctrl;
    ctrl_t      w_out;

    assign w_mem_state = is_mem_state(r_state);
    // mem_ready on the limit cycle wins, so only a still-stalled access times out
    assign w_timeout   = w_mem_state && !mem_ready && w_expired;
    assign w_wait_inc  = w_mem_state && !mem_ready;
    assign w_wait_clr  = mem_ready || (w_next != r_state);

    mc_wait_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_wait_clr),
        .inc     (w_wait_inc),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready)      w_next = ST_DECODE;
                else if (w_expired) w_next = ST_HALT;
            end
            ST_DECODE: begin
                case (op)
                    OP_RTYPE:     w_next = ST_EXEC_R;
                    OP_ORI:       w_next = ST_EXEC_I;
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_BEQ:       w_next = ST_BRANCH;
                    OP_JAL:       w_next = ST_JAL;
                    default:      w_next = ST_FETCH;
                endcase
            end
            ST_MEMADR: w_next = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (mem_ready)      w_next = ST_MEMWB;
                else if (w_expired) w_next = ST_HALT;
            end
            ST_MEMWR: begin
                if (mem_ready)      w_next = ST_FETCH;
                else if (w_expired) w_next = ST_HALT;
            end
            ST_EXEC_R: w_next = ST_RWB;
            ST_EXEC_I: w_next = ST_IWB;
            ST_MEMWB, ST_RWB, ST_IWB, ST_BRANCH, ST_JAL: w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // State and sticky error registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-state control decode; memory-side write enables follow mem_ready
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.iord      = 1'b0;
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // ALUOut captures PC+4 + (sext(imm)<<2) for a possible beq
                w_ctrl.alu_src_a  = 1'b0;
                w_ctrl.alu_src_b  = SRCB_BRANCH;
                w_ctrl.ext_op     = 1'b1;
                w_ctrl.alu_op     = ALUOP_ADD;
                // Only unsupported opcodes fall straight back to FETCH
                w_ctrl.illegal_op = (w_next == ST_FETCH);
            end
            ST_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.ext_op    = 1'b1;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                w_ctrl.mem_req  = 1'b1;
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                w_ctrl.reg_dst    = REGDST_RT;
                w_ctrl.mem_to_reg = MEMTOREG_MDR;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.iord       = 1'b1;
                w_ctrl.mem_write  = mem_ready;
                w_ctrl.instr_done = mem_ready;
            end
            ST_EXEC_R: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = ALUOP_RTYPE;
            end
            ST_RWB: begin
                w_ctrl.reg_dst    = REGDST_RD;
                w_ctrl.mem_to_reg = MEMTOREG_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            ST_EXEC_I: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.ext_op    = 1'b0;
                w_ctrl.alu_op    = ALUOP_ORI;
            end
            ST_IWB: begin
                w_ctrl.reg_dst    = REGDST_RT;
                w_ctrl.mem_to_reg = MEMTOREG_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SRCB_REG;
                w_ctrl.alu_op        = ALUOP_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
                w_ctrl.instr_done    = 1'b1;
            end
            ST_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                w_ctrl.reg_dst    = REGDST_RA;
                w_ctrl.mem_to_reg = MEMTOREG_PC;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = PCSRC_JUMP;
                w_ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset forces every strobe low at once, independent of the clock
    assign w_out = rst ? '0 : w_ctrl;

    assign mem_req     = w_out.mem_req;
    assign MemRead     = w_out.mem_read;
    assign MemWrite    = w_out.mem_write;
    assign IorD        = w_out.iord;
    assign IRWrite     = w_out.ir_write;
    assign PCWrite     = w_out.pc_write;
    assign PCWriteCond = w_out.pc_write_cond;
    assign PCSource    = w_out.pc_source;
    assign ALUSrcA     = w_out.alu_src_a;
    assign ALUSrcB     = w_out.alu_src_b;
    assign ExtOp       = w_out.ext_op;
    assign ALUOp       = w_out.alu_op;
    assign RegDst      = w_out.reg_dst;
    assign MemtoReg    = w_out.mem_to_reg;
    assign RegWrite    = w_out.reg_write;
    assign instr_done  = w_out.instr_done;
    assign illegal_op  = w_out.illegal_op;
    assign mem_err     = r_mem_err;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Scoreboard bench for multicycle_ctrl. A random instruction
//               stream is generated up front; a reference model turns each
//               instruction into its expected retirement record. A memory
//               responder plays back per-access wait counts, and a monitor
//               pops and compares a record at every retirement pulse.
//               Directed phases cover reset mid-instruction and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int WAIT_W   = 8;
    localparam int MAX_WAIT = 200;
    localparam int NINSTR   = 40;

    localparam int K_R = 0, K_ORI = 1, K_BEQ = 2, K_LW = 3, K_SW = 4, K_JAL = 5, K_ILL = 6;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSource, ALUSrcB, ALUOp, RegDst, MemtoReg;
    logic       ALUSrcA, ExtOp, RegWrite, instr_done, illegal_op, mem_err;
    logic [3:0] state_o;

    multicycle_ctrl #(.WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
        .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] ctl_bus;
    assign ctl_bus = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
                      PCSource, ALUSrcA, ALUSrcB, ExtOp, ALUOp, RegDst, MemtoReg,
                      RegWrite, instr_done, illegal_op};

    typedef struct {
        logic [1:0] kind;    // {instr_done, illegal_op} at retirement
        int         lat;     // cycles from first FETCH cycle to retirement
        int         irw;     // cycle index of the IRWrite strobe
        logic [3:0] st;      // state at retirement
        logic [9:0] fin;     // {RegWrite,RegDst,MemtoReg,PCWrite,PCSource,PCWriteCond,MemWrite}
        logic [5:0] dec;     // {ALUSrcA,ALUSrcB,ExtOp,ALUOp} in the cycle after IRWrite
        logic [5:0] exe;     // same fields two cycles after IRWrite
        bit         has_exe;
        int         n_mw, n_rw, n_pcw, n_mr, n_req;
    } exp_t;

    exp_t       exp_q[$];
    int         wait_q[$];
    logic [5:0] op_q[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;
    bit  stuck    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what one instruction must look like, from the ISA rules
    function automatic exp_t model(input int k, input int f, input int d);
        exp_t e;
        e.kind = 2'b10; e.irw = f + 1; e.dec = 6'b0_11_1_00; e.has_exe = 1'b1;
        e.n_mw = 0; e.n_rw = 0; e.n_pcw = 1; e.n_mr = f + 1; e.n_req = f + 1;
        e.lat = 0; e.st = 4'd0; e.fin = '0; e.exe = '0;
        case (k)
            K_R:   begin e.lat = f + 4; e.st = 4'd7;  e.fin = 10'b1_01_00_0_00_0_0;
                         e.exe = 6'b1_00_0_10; e.n_rw = 1; end
            K_ORI: begin e.lat = f + 4; e.st = 4'd9;  e.fin = 10'b1_00_00_0_00_0_0;
                         e.exe = 6'b1_10_0_11; e.n_rw = 1; end
            K_BEQ: begin e.lat = f + 3; e.st = 4'd10; e.fin = 10'b0_00_00_0_01_1_0;
                         e.exe = 6'b1_00_0_01; end
            K_LW:  begin e.lat = f + d + 5; e.st = 4'd4; e.fin = 10'b1_00_01_0_00_0_0;
                         e.exe = 6'b1_10_1_00; e.n_rw = 1;
                         e.n_mr += d + 1; e.n_req += d + 1; end
            K_SW:  begin e.lat = f + d + 4; e.st = 4'd5; e.fin = 10'b0_00_00_0_00_0_1;
                         e.exe = 6'b1_10_1_00; e.n_mw = 1; e.n_req += d + 1; end
            K_JAL: begin e.lat = f + 3; e.st = 4'd11; e.fin = 10'b1_10_10_1_10_0_0;
                         e.exe = 6'b0_00_0_00; e.n_rw = 1; e.n_pcw = 2; end
            default: begin e.kind = 2'b01; e.lat = f + 2; e.st = 4'd1; e.has_exe = 1'b0; end
        endcase
        return e;
    endfunction

    // Memory responder: each access waits its scripted number of cycles.
    // Outside an access mem_ready is random noise that must be ignored.
    initial begin : p_mem
        int  wcnt, tgt;
        bit  active;
        mem_ready = 1'b0; op = 6'h00; wcnt = 0; tgt = 0; active = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                mem_ready = 1'b0; active = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    active = 1'b1; wcnt = 0;
                    tgt = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                end
                if (stuck) begin
                    mem_ready = 1'b0;
                end else if (wcnt == tgt) begin
                    mem_ready = 1'b1; active = 1'b0;
                    if (!IorD && op_q.size() > 0) op = op_q.pop_front();
                end else begin
                    mem_ready = 1'b0; wcnt++;
                end
            end else begin
                active = 1'b0;
                mem_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: accumulate per-instruction activity, compare on retirement
    initial begin : p_mon
        int cyc, irw_at, n_mw, n_rw, n_pcw, n_mr, n_req, n_irw;
        logic [5:0] dec_s, exe_s;
        logic [3:0] dec_st;
        exp_t e;
        cyc = 0; irw_at = 0; n_mw = 0; n_rw = 0; n_pcw = 0; n_mr = 0; n_req = 0; n_irw = 0;
        dec_s = '0; exe_s = '0; dec_st = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                if (MemWrite) n_mw++;
                if (RegWrite) n_rw++;
                if (PCWrite)  n_pcw++;
                if (MemRead)  n_mr++;
                if (mem_req)  n_req++;
                if (IRWrite) begin n_irw++; irw_at = cyc; end
                if (irw_at > 0 && cyc == irw_at + 1) begin
                    dec_s = {ALUSrcA, ALUSrcB, ExtOp, ALUOp}; dec_st = state_o;
                end
                if (irw_at > 0 && cyc == irw_at + 2) exe_s = {ALUSrcA, ALUSrcB, ExtOp, ALUOp};
                if (instr_done || illegal_op) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("retire_kind", {instr_done, illegal_op}, e.kind);
                        chk("latency", cyc, e.lat);
                        chk("irwrite_cycle", irw_at, e.irw);
                        chk("irwrite_count", n_irw, 1);
                        chk("retire_state", state_o, e.st);
                        chk("retire_ctrl", {RegWrite, RegDst, MemtoReg, PCWrite, PCSource,
                                            PCWriteCond, MemWrite}, e.fin);
                        chk("decode_state", dec_st, 1);
                        chk("decode_alu", dec_s, e.dec);
                        if (e.has_exe) chk("exec_alu", exe_s, e.exe);
                        chk("memwrite_cycles", n_mw, e.n_mw);
                        chk("regwrite_cycles", n_rw, e.n_rw);
                        chk("pcwrite_cycles", n_pcw, e.n_pcw);
                        chk("memread_cycles", n_mr, e.n_mr);
                        chk("memreq_cycles", n_req, e.n_req);
                    end
                    cyc = 0; irw_at = 0; n_mw = 0; n_rw = 0; n_pcw = 0;
                    n_mr = 0; n_req = 0; n_irw = 0;
                end
            end
        end
    end

    // Stimulus and directed phases
    initial begin : p_main
        logic [5:0] codes [7];
        int   k, f, d, stall;
        bit   found, first_ill;
        logic [5:0] x;
        codes[K_R] = 6'h00; codes[K_ORI] = 6'h0D; codes[K_BEQ] = 6'h04;
        codes[K_LW] = 6'h23; codes[K_SW] = 6'h2B; codes[K_JAL] = 6'h03; codes[K_ILL] = 6'h3F;
        rst = 1'b1;
        first_ill = 1'b1;

        for (int i = 0; i < NINSTR; i++) begin
            k = (i < 7) ? i : int'($urandom_range(0, 6));
            f = int'($urandom_range(0, 3));
            d = int'($urandom_range(0, 3));
            if (i == 3) begin f = MAX_WAIT; d = MAX_WAIT - 1; end  // lw: stall right at the limit
            if (i == 4) begin f = 0;        d = MAX_WAIT;     end  // sw: ready on the limit cycle
            x = codes[k];
            if (k == K_ILL && !first_ill) begin
                do x = 6'($urandom_range(0, 63));
                while (x == 6'h00 || x == 6'h0D || x == 6'h04 || x == 6'h23 ||
                       x == 6'h2B || x == 6'h03);
            end
            if (k == K_ILL) first_ill = 1'b0;
            op_q.push_back(x);
            wait_q.push_back(f);
            if (k == K_LW || k == K_SW) wait_q.push_back(d);
            exp_q.push_back(model(k, f, d));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", ctl_bus, 0);
        chk("reset_state", state_o, 0);
        chk("reset_mem_err", mem_err, 0);

        @(posedge clk); #1;
        rst = 1'b0; mon_en = 1'b1;

        for (int c = 0; c < 8000 && exp_q.size() != 0; c++) begin
            @(negedge clk); #1;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // Reset while in DECODE: strobes must drop in the same cycle
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (state_o == 4'd1) begin found = 1'b1; break; end
        end
        chk("find_decode", found, 1);
        rst = 1'b1; stuck = 1'b1;
        #1;
        chk("midrst_ctrl", ctl_bus, 0);
        chk("midrst_state", state_o, 0);

        // Release with memory stuck: FETCH must time out into HALT
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_state", state_o, 0);
        chk("post_rst_req", mem_req, 1);
        stall = 0;
        for (int c = 0; c < 1000; c++) begin
            if (state_o == 4'd15) break;
            if (state_o == 4'd0 && mem_req && !mem_ready) stall++;
            @(negedge clk);
        end
        chk("halt_state", state_o, 15);
        chk("stall_cycles", stall, MAX_WAIT + 1);
        chk("halt_mem_err", mem_err, 1);
        chk("halt_ctrl", ctl_bus, 0);

        // HALT ignores mem_ready activity and exits only on reset
        stuck = 1'b0;
        repeat (20) @(negedge clk);
        chk("halt_held", state_o, 15);
        chk("halt_err_sticky", mem_err, 1);

        rst = 1'b1;
        #1;
        chk("final_rst_state", state_o, 0);
        chk("final_rst_err", mem_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore FSM that sequences the shared multicycle MIPS datapath: one ALU, one unified memory port, and IR/A/B/ALUOut/MDR registers.
It issues per-state control strobes for addu, subu, ori, lw, sw, beq and jal.
It stalls on a memory ready handshake and halts on a memory timeout.
It replaces the single-cycle main decoder; the existing ALU-control decoder still consumes ALUOp and Funct.

Parameters:
WAIT_W, 8, width of the memory wait counter
MAX_WAIT, 200, memory-stall cycles tolerated before mem_err (must be < 2**WAIT_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
op  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
MemRead  out  1  read access (qualifies mem_req)
MemWrite  out  1  write access (qualifies mem_req)
IorD  out  1  0=PC address, 1=ALUOut address
IRWrite  out  1  load IR from memory read data
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=extended imm, 11=sign-ext imm<<2
ExtOp  out  1  0=zero-extend, 1=sign-extend
ALUOp  out  2  to ALU-control decoder
RegDst  out  2  00=rt, 01=rd, 10=$31
MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC
RegWrite  out  1  register file write
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_op  out  1  one-cycle pulse on an unsupported opcode
mem_err  out  1  sticky memory timeout flag
state_o  out  4  current state, for debug

Behaviour:
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RWB=7, EXEC_I=8, IWB=9, BRANCH=10, JAL=11, HALT=15.
- Reset:
  - State goes to FETCH immediately; wait counter is cleared; mem_err is cleared.
  - While rst=1, every output is 0, including mem_req and all write enables.
  - A reset mid-instruction abandons the instruction with no partial writes after rst rises.
- Outputs are a combinational decode of the state; write enables in memory states are additionally gated by mem_ready. Signals not listed for a state are 0.
- FETCH:
  - Always: mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD.
  - IRWrite and PCWrite (PCSource=00) are asserted only when mem_ready=1, which also advances to DECODE. Otherwise the FSM stays in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=ADD, so ALUOut captures the branch target. Next state by op:
  - 0x00 -> EXEC_R
  - 0x0D -> EXEC_I
  - 0x23 or 0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x03 -> JAL
  - anything else -> FETCH, with illegal_op pulsed.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=ADD. Goes to MEMRD if op=0x23, else MEMWR.
- MEMRD: mem_req=1, MemRead=1, IorD=1. Advances to MEMWB on mem_ready.
- MEMWB: RegDst=00, MemtoReg=01, RegWrite=1, instr_done=1. Goes to FETCH.
- MEMWR: mem_req=1, MemWrite=1 (gated by mem_ready), IorD=1. On mem_ready: instr_done=1 and go to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE. Goes to RWB.
- RWB: RegDst=01, MemtoReg=00, RegWrite=1, instr_done=1. Goes to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUOp=ORI. Goes to IWB.
- IWB: RegDst=00, MemtoReg=00, RegWrite=1, instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01, instr_done=1. Goes to FETCH.
- JAL: RegDst=10, MemtoReg=10 (PC already holds PC+4), RegWrite=1, PCWrite=1, PCSource=10, instr_done=1. Goes to FETCH.
- Latency with zero wait states, in cycles: R-type 4, ori 4, lw 5, sw 4, beq 3, jal 3. Each memory wait cycle adds 1.
- Wait counter:
  - Increments in FETCH, MEMRD and MEMWR each cycle that mem_ready=0; clears on mem_ready or on any state change.
  - When the count reaches MAX_WAIT with mem_ready still 0: mem_err is set and the FSM goes to HALT.
  - HALT: all outputs 0, mem_err=1; exits only on reset.
  - mem_ready in the same cycle as the limit takes priority, and the access completes.
- mem_ready outside a memory state is ignored.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings;
  - opcode constants (0x00, 0x0D, 0x23, 0x2B, 0x04, 0x03);
  - ALUOp codes ADD=2'b00, SUB=2'b01, RTYPE=2'b10, ORI=2'b11;
  - ALUSrcB, PCSource, RegDst and MemtoReg mux codes.
- One natural sub-module, mc_wait_timer: wait counter plus MAX_WAIT compare, with inputs clr/inc and output expired.

Test Plan:
- Reset in DECODE: raise rst -> all outputs 0 in the same cycle; after release, state_o=0, mem_req=1.
- addu (op 0x00), mem_ready tied to 1 -> states 0,1,6,7; RegWrite=1 with RegDst=01 in cycle 4; instr_done pulses in cycle 4.
- lw (op 0x23), MEMRD ready held low 3 cycles -> 8 total cycles; MemtoReg=01 and RegWrite=1 only in MEMWB.
- sw (op 0x2B) then beq (op 0x04) -> MemWrite high exactly 1 cycle (gated by ready); beq: PCWriteCond=1, PCSource=01 in cycle 3.
- jal (op 0x03) then illegal op 0x3F -> jal: RegDst=10, MemtoReg=10, PCWrite=1, PCSource=10 in cycle 3; illegal: illegal_op pulses in DECODE, next state FETCH, no RegWrite.
- FETCH with mem_ready stuck low and MAX_WAIT=200 -> mem_err=1 after 200 stall cycles, state_o=15 held until rst.
